// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding memory access sequencer.
// Latches a CPU request into MAR/MDR, gives the memory one setup cycle,
// holds the rd/wr strobe for STROBE_CYCLES cycles, and signals completion
// with a one-cycle done pulse. Every output comes straight from a flop.
module mem_ctrl #(
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 16,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_out,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // Strobe-length counter; STROBE_CYCLES is limited to 1..15.
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;
  logic              w_finish;

  // MAR/MDR double as the memory-facing address/data registers.
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_op;       // 1 = write

  logic              r_ready;
  logic              r_done;
  logic              r_rd;
  logic              r_wr;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wr_cnt;

  // Next-state logic: accept in IDLE, count strobe cycles, flag completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_STROBE;
        w_cnt_nxt   = CNT_LOAD;
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and strobe counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request latch: address/data/op only change on acceptance, so they stay
  // frozen from SETUP through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mar <= '0;
      r_mdr <= '0;
      r_op  <= 1'b0;
    end else if (w_accept) begin
      r_mar <= cpu_addr;
      r_mdr <= cpu_wdata;
      r_op  <= cpu_we;
    end
  end

  // Handshake and strobe outputs decoded from the next state so they are
  // registered. r_op is already stable when STROBE is entered from SETUP,
  // so the strobe never rises on the edge that moves the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      r_rd    <= (w_state_nxt == ST_STROBE) && !r_op;
      r_wr    <= (w_state_nxt == ST_STROBE) &&  r_op;
    end
  end

  // Read capture on the last strobe edge, while rd is still high; the
  // memory zeroes its output once rd drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_finish && !r_op) begin
      r_rdata <= mem_out;
    end
  end

  // Saturating completion counters, bumped on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_finish) begin
      if (r_op) begin
        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end else begin
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign cpu_ready = r_ready;
  assign cpu_done  = r_done;
  assign cpu_rdata = r_rdata;
  assign mem_addr  = r_mar;
  assign mem_in    = r_mdr;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: two controllers (N=1 and N=3), each with its own 32x16
// memory model, checked against a word-level reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, sel;
  logic [4:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        req0, req1;

  logic        ready0, done0, rd0, wr0, ready1, done1, rd1, wr1;
  logic [15:0] rdata0, in0, mout0, rc0, wc0, rdata1, in1, mout1, rc1, wc1;
  logic [4:0]  addr0, addr1;

  logic [15:0] mem0 [32];
  logic [15:0] mem1 [32];
  logic        pl_we;
  logic [4:0]  pl_a;
  logic [15:0] pl_d;

  logic        ready_s, done_s, rd_s, wr_s;
  logic [15:0] rdata_s, in_s;
  logic [4:0]  addr_s;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [15:0] model [32];
  int          m_rc, m_wc;
  logic [15:0] m_rdata;

  always #5 clk = ~clk;

  assign req0 = cpu_req & ~sel;
  assign req1 = cpu_req &  sel;

  mem_ctrl #(.ADDR_W(5), .DATA_W(16), .STROBE_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .cpu_req(req0), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(ready0),
    .cpu_done(done0), .cpu_rdata(rdata0), .mem_addr(addr0), .mem_in(in0),
    .mem_rd(rd0), .mem_wr(wr0), .mem_out(mout0), .rd_count(rc0), .wr_count(wc0));

  mem_ctrl #(.ADDR_W(5), .DATA_W(16), .STROBE_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_req(req1), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(ready1),
    .cpu_done(done1), .cpu_rdata(rdata1), .mem_addr(addr1), .mem_in(in1),
    .mem_rd(rd1), .mem_wr(wr1), .mem_out(mout1), .rd_count(rc1), .wr_count(wc1));

  // Memories: output is zero while rd is low; writes land while wr is high.
  assign mout0 = rd0 ? mem0[addr0] : 16'h0;
  assign mout1 = rd1 ? mem1[addr1] : 16'h0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem0[pl_a] <= pl_d;
      mem1[pl_a] <= pl_d;
    end else begin
      if (wr0) mem0[addr0] <= in0;
      if (wr1) mem1[addr1] <= in1;
    end
  end

  assign ready_s = sel ? ready1 : ready0;
  assign done_s  = sel ? done1  : done0;
  assign rd_s    = sel ? rd1    : rd0;
  assign wr_s    = sel ? wr1    : wr0;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign in_s    = sel ? in1    : in0;
  assign addr_s  = sel ? addr1  : addr0;

  // Protocol watch: no overlapping strobes, no strobe while the address moves.
  logic [4:0] pa0 = '0, pa1 = '0;
  always @(negedge clk) begin
    if (rd0 && wr0) viol <= viol + 1;
    if (rd1 && wr1) viol <= viol + 1;
    if ((rd0 || wr0) && addr0 != pa0) viol <= viol + 1;
    if ((rd1 || wr1) && addr1 != pa1) viol <= viol + 1;
    pa0 <= addr0;
    pa1 <= addr1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One access on the selected DUT. k counts negedges after the accepting
  // edge (k=1 is the SETUP cycle).
  task automatic access(input logic we, input logic [4:0] a, input logic [15:0] d,
                        output logic [15:0] rdat, output int done_k, output int rdn,
                        output int wrn, output int first_k, output int addr_ok,
                        output int din_ok, output int rdy_after);
    int w;
    rdat = '0; done_k = 0; rdn = 0; wrn = 0; first_k = 0;
    addr_ok = 1; din_ok = 1; rdy_after = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    w = 0;
    while (!ready_s && w < 50) begin @(negedge clk); w++; end
    if (!ready_s) begin
      chk("accept_timeout", 0, 1);
      cpu_req = 1'b0;
      return;
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) cpu_req = 1'b0;
      if (rd_s || wr_s) begin
        if (first_k == 0) first_k = k;
        if (rd_s) rdn++;
        if (wr_s) wrn++;
      end
      if (addr_s != a) addr_ok = 0;
      if (we && in_s != d) din_ok = 0;
      if (done_k != 0 && k == done_k + 1) begin
        rdy_after = int'(ready_s);
        break;
      end
      if (done_s && done_k == 0) begin
        done_k = k;
        rdat   = rdata_s;
      end
    end
    if (done_k == 0) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rdata;
    int          exp_rc;
    int          exp_wc;
  } vec_t;

  vec_t tv [5];

  initial begin
    logic [15:0] rdat;
    int dk, rn, wn, fk, aok, dok, rdy;
    int acc_t [2];
    int acc_n, ndone, pulses, w, seen;
    logic prev_rd, drop;
    logic [15:0] got [2];

    tv[0] = '{1'b0, 5'd0, 16'h0000, 16'h0003, 1, 0};
    tv[1] = '{1'b1, 5'd5, 16'h00AA, 16'h0003, 1, 1};
    tv[2] = '{1'b0, 5'd5, 16'h0000, 16'h00AA, 2, 1};
    tv[3] = '{1'b0, 5'd1, 16'h0000, 16'h0001, 3, 1};
    tv[4] = '{1'b0, 5'd2, 16'h0000, 16'h0003, 4, 1};

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; sel = 1'b0; pl_we = 1'b0; pl_a = '0; pl_d = '0;

    // Preload both memories while held in reset.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_a = 5'(i);
      pl_d  = (i == 0) ? 16'd3 : (i == 1) ? 16'd1 : (i == 2) ? 16'd3 : 16'($urandom);
      model[i] = pl_d;
    end
    @(negedge clk); pl_we = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready0), 1);
    chk("rst_done", int'(done0), 0);
    chk("rst_strobes", int'(rd0 | wr0 | rd1 | wr1), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_min", int'(in0), 0);
    chk("rst_rdata", int'(rdata0), 0);
    chk("rst_counts", int'(rc0) + int'(wc0), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd0 || wr0 || rd1 || wr1 || done0 || done1) seen++;
    end
    chk("idle_no_strobe", seen, 0);
    chk("idle_counts", int'(rc0) + int'(wc0), 0);
    m_rc = 0; m_wc = 0; m_rdata = '0;

    // N=3 controller: read addr 2.
    sel = 1'b1;
    access(1'b0, 5'd2, 16'h0, rdat, dk, rn, wn, fk, aok, dok, rdy);
    chk("n3_rd_pulse_len", rn, 3);
    chk("n3_wr_pulses", wn, 0);
    chk("n3_strobe_start", fk, 2);
    chk("n3_done_k", dk, 5);
    chk("n3_rdata", int'(rdat), 3);
    chk("n3_ready_back", rdy, 1);
    chk("n3_rd_count", int'(rc1), 1);
    sel = 1'b0;

    // Directed vector table on the N=1 controller.
    for (int i = 0; i < 5; i++) begin
      access(tv[i].we, tv[i].a, tv[i].d, rdat, dk, rn, wn, fk, aok, dok, rdy);
      if (tv[i].we) model[tv[i].a] = tv[i].d;
      chk($sformatf("tv%0d_rdata", i), int'(rdat), int'(tv[i].exp_rdata));
      chk($sformatf("tv%0d_done_k", i), dk, 3);
      chk($sformatf("tv%0d_strobe", i), tv[i].we ? wn : rn, 1);
      chk($sformatf("tv%0d_other_strobe", i), tv[i].we ? rn : wn, 0);
      chk($sformatf("tv%0d_strobe_start", i), fk, 2);
      chk($sformatf("tv%0d_addr_stable", i), aok, 1);
      chk($sformatf("tv%0d_wdata", i), dok, 1);
      chk($sformatf("tv%0d_ready_back", i), rdy, 1);
      chk($sformatf("tv%0d_rd_count", i), int'(rc0), tv[i].exp_rc);
      chk($sformatf("tv%0d_wr_count", i), int'(wc0), tv[i].exp_wc);
    end
    m_rc = 4; m_wc = 1; m_rdata = 16'h3;

    // Held request: two reads back to back, addr 1 then addr 2.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
    acc_n = 0; ndone = 0; pulses = 0; prev_rd = 1'b0; drop = 1'b0;
    got[0] = '0; got[1] = '0; acc_t[0] = 0; acc_t[1] = 0;
    for (int t = 0; t < 30 && ndone < 2; t++) begin
      if (t != 0) @(negedge clk);
      if (drop) begin cpu_req = 1'b0; drop = 1'b0; end
      if (rd0 && !prev_rd) pulses++;
      prev_rd = rd0;
      if (done0) begin
        if (ndone < 2) got[ndone] = rdata0;
        ndone++;
        cpu_addr = 5'd2;
      end
      if (ready0 && cpu_req && acc_n < 2) begin
        acc_t[acc_n] = t;
        acc_n++;
        if (acc_n == 2) drop = 1'b1;
      end
    end
    cpu_req = 1'b0;
    chk("hold_accepts", acc_n, 2);
    chk("hold_spacing", acc_t[1] - acc_t[0], 4);
    chk("hold_rdata0", int'(got[0]), 1);
    chk("hold_rdata1", int'(got[1]), 3);
    chk("hold_rd_pulses", pulses, 2);
    m_rc += 2; m_rdata = 16'h3;
    chk("hold_rd_count", int'(rc0), m_rc);

    // Reset during the write strobe.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 16'h1234;
    @(negedge clk);
    cpu_req = 1'b0;
    w = 0;
    while (!wr0 && w < 10) begin @(negedge clk); w++; end
    chk("mid_wr_seen", int'(wr0), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_wr_low", int'(wr0), 0);
    chk("mid_no_done", int'(done0), 0);
    chk("mid_ready", int'(ready0), 1);
    chk("mid_wr_count", int'(wc0), 0);
    chk("mid_rdata", int'(rdata0), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done0 || wr0) seen++;
    end
    chk("mid_quiet_after", seen, 0);
    model[7] = 16'h1234;   // the strobe was high across the reset edge
    m_rc = 0; m_wc = 0; m_rdata = '0;

    // Randomized accesses against the word-level model.
    for (int i = 0; i < 40; i++) begin
      logic        rwe;
      logic [4:0]  ra;
      logic [15:0] rdv;
      rwe = 1'($urandom_range(0, 1));
      ra  = 5'($urandom_range(0, 31));
      rdv = 16'($urandom);
      access(rwe, ra, rdv, rdat, dk, rn, wn, fk, aok, dok, rdy);
      if (rwe) begin
        model[ra] = rdv;
        m_wc++;
      end else begin
        m_rdata = model[ra];
        m_rc++;
      end
      chk($sformatf("rnd%0d_rdata", i), int'(rdat), int'(m_rdata));
      chk($sformatf("rnd%0d_done_k", i), dk, 3);
      chk($sformatf("rnd%0d_strobes", i), rn + wn, 1);
      chk($sformatf("rnd%0d_rd_count", i), int'(rc0), m_rc);
      chk($sformatf("rnd%0d_wr_count", i), int'(wc0), m_wc);
    end

    @(negedge clk);
    chk("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access sequencer between the multi-cycle CPU control path and the 32×16 data/instruction memory. It accepts one read or write request at a time over a req/ready handshake and latches address and write data into internal MAR/MDR registers. It drives the memory's level-sensitive `rd`/`wr` strobes with a setup cycle so the address is stable before any strobe edge. For reads it captures the memory output while the strobe is still high, then reports completion with a one-cycle `cpu_done` pulse.

## Interface
- `ADDR_W`, 5, memory address width (32 words).
- `DATA_W`, 16, data word width.
- `STROBE_CYCLES`, 1, cycles `mem_rd`/`mem_wr` stay high per access; legal range 1–15.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_req` input 1: request valid; held by requester until accepted.
- `cpu_we` input 1: 1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr` input ADDR_W: word address.
- `cpu_wdata` input DATA_W: write data.
- `cpu_ready` output 1: controller idle; request accepted on an edge where `cpu_req & cpu_ready`.
- `cpu_done` output 1: one-cycle completion pulse.
- `cpu_rdata` output DATA_W: last read data; valid from `cpu_done` and held until the next read completes.
- `mem_addr` output ADDR_W: registered address to memory.
- `mem_in` output DATA_W: registered write data to memory.
- `mem_rd` output 1: read strobe.
- `mem_wr` output 1: write strobe.
- `mem_out` input DATA_W: memory read data. It is 0 whenever `mem_rd` is low.
- `rd_count` output 16: completed reads, saturating at 0xFFFF.
- `wr_count` output 16: completed writes, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE. All outputs are registered.
- **IDLE**
  - `cpu_ready`=1; strobes low.
  - On `cpu_req`: MAR←`cpu_addr`, MDR←`cpu_wdata`, op←`cpu_we`; `mem_addr`/`mem_in` load from the request; go to SETUP.
- **SETUP** (1 cycle)
  - Address and data are driven; strobes low; `cpu_ready`=0.
  - Next state STROBE; the strobe counter loads STROBE_CYCLES−1.
- **STROBE**
  - Exactly one of `mem_rd`/`mem_wr` is high, selected by op. The counter decrements each cycle.
  - When the counter is 0, go to DONE.
  - Read: `cpu_rdata`←`mem_out` on that same edge, while `mem_rd` is still high. This is required because the memory zeroes its output when `rd` falls.
- **DONE** (1 cycle)
  - Strobes low; `mem_addr`/`mem_in` held; `cpu_done`=1.
  - The matching counter increments (saturating) on entry to DONE.
  - Next state IDLE.
- `mem_addr`/`mem_in` never change from SETUP through DONE.
- `mem_rd` and `mem_wr` are never high together. No strobe is ever asserted in the same cycle the address changes.
- A request presented while `cpu_ready`=0 is ignored. The requester holds it; it is accepted in IDLE.
- Write data is not echoed: `cpu_rdata` is unchanged by writes.
- **Reset**: on the reset edge, state→IDLE. `mem_rd`, `mem_wr`, `cpu_done` go to 0 on that edge, even mid-access. `mem_addr`, `mem_in`, `cpu_rdata`, `rd_count`, `wr_count`, MAR, MDR go to 0; `cpu_ready`=1. An interrupted access produces no `cpu_done` and no count increment.

## Timing
- Let A be the accepting edge and N = STROBE_CYCLES.
  - SETUP: cycle A→A+1.
  - Strobe high: edges A+1→A+1+N.
  - `cpu_done` high: A+1+N→A+2+N.
  - `cpu_ready` high again from edge A+2+N.
- Total occupancy is N+2 cycles. The earliest back-to-back accept is at edge A+N+3 (N=1: every 4 cycles).
- `cpu_rdata` updates at edge A+1+N, coincident with the rise of `cpu_done`.
- Counter saturation: 0xFFFF plus one completion stays 0xFFFF.
- No combinational path from any cpu_* input to any mem_* output.

## Test plan
- **Reset** held 2 cycles → all outputs 0 except `cpu_ready`=1; 10 idle cycles with `cpu_req`=0 → no strobe, counts 0.
- **Read, N=1**: read addr 0 (memory preloaded with 3).
  - `mem_rd` high exactly 1 cycle, starting 1 cycle after accept.
  - `cpu_done` at A+2, `cpu_rdata`=3, `rd_count`=1.
  - `mem_addr`=0 stable A..A+3.
- **Write then read**: write 0x00AA to addr 5, then read addr 5.
  - Write: `mem_wr` 1 cycle with `mem_in`=0x00AA.
  - Read: returns 0x00AA; `wr_count`=1, `rd_count`=1; `cpu_rdata` unchanged after the write's `cpu_done`.
- **Held request**: `cpu_req` held continuously for two reads (addr 1, then addr 2 after first done) → accepts 4 cycles apart; `cpu_rdata` 1 then 3; exactly two `mem_rd` pulses.
- **Reset mid-access**: reset asserted during STROBE of a write → `mem_wr`=0 after that edge; no `cpu_done`; `wr_count`=0; `cpu_ready`=1 after that edge.
- **STROBE_CYCLES=3**: read addr 2 → `mem_rd` high 3 consecutive cycles; `cpu_done` at A+4 with `cpu_rdata`=3; `cpu_ready` back at A+5.
